// File: rtl/microsequencer.sv
// Microstep sequencer: owns the decoder step counter, gates datapath commits,
// and provides panel run / single-step / halt / resume control with a runaway-microcode trap.
module microsequencer #(
  parameter int INSTRUCTION_STEPS  = 32,
  parameter int CONTROL_WORD_WIDTH = 32,
  parameter int ADV_BIT            = 0,
  parameter int HLT_BIT            = 1,
  parameter int RETIRE_WIDTH       = 32,
  localparam int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [CONTROL_WORD_WIDTH-1:0] i_control_word,
  input  logic                          i_run,
  input  logic                          i_single_step,
  input  logic                          i_step_instr,
  input  logic                          i_resume,
  output logic [STEP_WIDTH-1:0]         o_step,
  output logic                          o_exec,
  output logic                          o_halted,
  output logic                          o_fault,
  output logic [RETIRE_WIDTH-1:0]       o_retired
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    RUN_ONE = 3'd2,
    MICRO   = 3'd3,
    HALTED  = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  state_t                  state_q, state_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
  logic                    ss_q;
  logic                    ss_rise;
  logic                    exec;
  logic                    c_hlt, c_adv;

  assign ss_rise = i_single_step & ~ss_q;
  assign exec    = (state_q == RUN) || (state_q == RUN_ONE) || (state_q == MICRO);
  assign c_hlt   = i_control_word[HLT_BIT];
  assign c_adv   = i_control_word[ADV_BIT];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      step_q    <= '0;
      retired_q <= '0;
      ss_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      retired_q <= retired_d;
      ss_q      <= i_single_step;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    retired_d = retired_q;
    if (exec) begin
      // HLT outranks ADV; a missing ADV on the last step means runaway microcode
      if (c_hlt) begin
        retired_d = retired_q + RETIRE_WIDTH'(1);
        state_d   = HALTED;
      end else if (c_adv) begin
        step_d    = '0;
        retired_d = retired_q + RETIRE_WIDTH'(1);
        if (state_q != RUN || !i_run) state_d = IDLE;
      end else if (step_q == LAST_STEP) begin
        state_d = FAULT;
      end else begin
        step_d = step_q + STEP_WIDTH'(1);
        if (state_q == MICRO) state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (i_run)        state_d = RUN;
          else if (ss_rise) state_d = i_step_instr ? RUN_ONE : MICRO;
        end
        HALTED: begin
          if (i_resume) begin
            step_d  = '0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_step    = step_q;
  assign o_exec    = exec;
  assign o_halted  = (state_q == HALTED);
  assign o_fault   = (state_q == FAULT);
  assign o_retired = retired_q;

endmodule
